iob2axi_wr_split: RTL and testbench
===================================

IOB2AXI_WR_SPLIT -- requirements
Module: iob2axi_wr_split

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, native and AXI address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, data width in bits; a power of 2, at least 8.
REQ-003 SHALL have parameter LEN_W, default 16, width of the transfer word count.
REQ-004 SHALL have parameter MAX_BURST, default 16, maximum beats per AXI burst; a power of 2, 1..256.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk_i, input, 1, clock; arst_n_i, input, 1, asynchronous active-low reset.
REQ-006 SHALL have the following control ports:
- run_i, input, 1, start pulse.
- addr_i, input, ADDR_W, start byte address.
- nwords_i, input, LEN_W, total words to write.
- busy_o, output, 1, transfer in progress.
- done_o, output, 1, one-cycle completion pulse.
- error_o, output, 1, OR of all BRESPs in the last transfer.
REQ-007 SHALL have an AXI4 write master on the standard m_axi_aw*/w*/b* ports with an AXI_LEN_W-wide awlen.
REQ-008 SHALL have the following native read master ports:
- m_valid_o, output, 1.
- m_addr_o, output, ADDR_W.
- m_rdata_i, input, DATA_W.
- m_rstrb_i, input, DATA_W/8.
- m_ready_i, input, 1; data is valid in the cycle m_ready_i=1.

Function
REQ-009 SHALL capture addr_i (low log2(DATA_W/8) bits forced to 0) and nwords_i on run_i when idle; run_i while busy_o=1 is ignored.
REQ-010 SHALL split the transfer into consecutive INCR bursts, each of length min(remaining, MAX_BURST, words to the next 4 KB boundary).
REQ-011 SHALL run the FSM IDLE -> AW -> DATA -> RESP -> (AW if words remain, else IDLE).
REQ-012 In AW, SHALL hold awvalid=1 with a stable awaddr and awlen=len-1 until awready, then move to DATA.
REQ-013 SHALL drive awsize=log2(DATA_W/8), awburst=INCR, awcache=2, awprot=2, and zero for id, lock and qos.
REQ-014 In DATA, SHALL use a one-entry buffer:
- m_valid_o=1 while unfetched beats remain and the buffer is empty or draining this cycle.
- m_ready_i loads m_rdata_i/m_rstrb_i into the buffer.
- wvalid = buffer full.
REQ-015 SHALL set m_addr_o to the current burst address plus (fetched beats x DATA_W/8).
REQ-016 SHALL assert wlast only on the final beat of each burst, and SHALL move to RESP on the wvalid&wready of that beat.
REQ-017 SHALL hold bready=1 only in RESP; on bvalid, error_o |= |bresp, and remaining words and address advance by the burst length.
REQ-018 SHALL clear error_o on an accepted run_i; error_o then holds until the next run.
REQ-019 SHALL set busy_o=1 from the cycle after an accepted run_i until done_o.
REQ-020 SHALL pulse done_o for one cycle on the last bvalid handshake.
REQ-021 With nwords_i=0, SHALL generate no AXI or native traffic and SHALL pulse done_o the cycle after run_i.
REQ-022 SHALL keep going after an error response; the transfer always completes all bursts.
REQ-023 SHALL not allow AXI or native signal changes that violate valid/ready stability while a handshake is pending.

Reset
REQ-024 SHALL, on arst_n_i=0, immediately set state=IDLE, drive busy_o, done_o, error_o, awvalid, wvalid, bready and m_valid_o to 0, and empty the buffer.
REQ-025 A reset mid-transfer SHALL abandon the transfer with no done_o pulse; the first cycle after reset release SHALL accept run_i.

Structure
REQ-026 SHALL take the following constants from the shared iob2axi package/header: AXI_LEN_W, AXI_ID_W, AXI_BURST_W, AXI_LOCK_W, AXI_CACHE_W, AXI_PROT_W, AXI_QOS_W, the INCR encoding and the 4 KB boundary constant.
REQ-027 SHALL use a combinational sub-module iob2axi_burst_len(addr, remaining) -> burst length, instantiated once.

Verification (DATA_W=32, MAX_BURST=16)
REQ-028 addr 0x000, n=16 -> one burst: awaddr 0x000, awlen 15, 16 beats, wlast on beat 16, done_o once.
REQ-029 addr 0x000, n=40 -> three bursts: awaddr 0x000/0x040/0x080, awlen 15/15/7.
REQ-030 addr 0xFF8, n=4 -> two bursts: 0xFF8 awlen 1, then 0x1000 awlen 1; no burst crosses 4 KB.
REQ-031 n=0 -> done_o the cycle after run_i; awvalid and m_valid_o never asserted.
REQ-032 n=40 with wready toggling 1010 and burst 2 bresp=SLVERR -> all 40 words written in order, no beat lost or duplicated, error_o=1 at done_o.
REQ-033 arst_n_i low in the middle of burst 2 -> all outputs 0 that cycle, no done_o; a new run (addr 0x100, n=4) then completes normally.

Source files
------------

// File: rtl/iob2axi_pkg.sv
// Shared AXI4 field widths, encodings and write-split FSM state codes for the
// iob2axi bridge family.
package iob2axi_pkg;

  localparam int AXI_LEN_W   = 8;
  localparam int AXI_ID_W    = 1;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_LOCK_W  = 1;
  localparam int AXI_CACHE_W = 4;
  localparam int AXI_PROT_W  = 3;
  localparam int AXI_QOS_W   = 4;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_RESP_W  = 2;

  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;

  // A burst may not cross a 4 KB page: AXI_4K_W address bits index the page.
  localparam int AXI_4K_W = 12;
  localparam int AXI_4K   = 4096;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AW   = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/iob2axi_wr_split_burst_len.sv
// Combinational burst sizer: min(remaining words, MAX_BURST, words left in
// the current 4 KB page). Returns 0 only when remaining is 0.
module iob2axi_burst_len
  import iob2axi_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 16,
  parameter int BL_W      = $clog2(MAX_BURST) + 1
) (
  input  logic [AXI_4K_W-1:0] addr_i,
  input  logic [LEN_W-1:0]    remaining_i,
  output logic [BL_W-1:0]     len_o
);

  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int CMP_W   = ((LEN_W > AXI_4K_W) ? LEN_W : AXI_4K_W) + 1;
  localparam logic [AXI_4K_W:0] PAGE_BYTES = (AXI_4K_W + 1)'(AXI_4K);

  logic [AXI_4K_W:0] bound_bytes;
  logic [CMP_W-1:0]  bound_words;
  logic [CMP_W-1:0]  rem_w;
  logic [CMP_W-1:0]  len_w;

  always_comb begin
    bound_bytes = PAGE_BYTES - {1'b0, addr_i};
    bound_words = CMP_W'(bound_bytes >> BYTE_SH);
    rem_w       = CMP_W'(remaining_i);
    len_w       = CMP_W'(MAX_BURST);
    if (rem_w < len_w) len_w = rem_w;
    if (bound_words < len_w) len_w = bound_words;
    len_o = BL_W'(len_w);
  end

endmodule

// File: rtl/iob2axi_wr_split.sv
// Copies nwords words from a native read port to an AXI4 write master,
// splitting the transfer into 4 KB-safe INCR bursts of at most MAX_BURST beats.
module iob2axi_wr_split
  import iob2axi_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  // control
  input  logic                   run_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [LEN_W-1:0]       nwords_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [1:0]             state_o,
  // AXI4 write address channel
  output logic [AXI_ID_W-1:0]    m_axi_awid_o,
  output logic [ADDR_W-1:0]      m_axi_awaddr_o,
  output logic [AXI_LEN_W-1:0]   m_axi_awlen_o,
  output logic [AXI_SIZE_W-1:0]  m_axi_awsize_o,
  output logic [AXI_BURST_W-1:0] m_axi_awburst_o,
  output logic [AXI_LOCK_W-1:0]  m_axi_awlock_o,
  output logic [AXI_CACHE_W-1:0] m_axi_awcache_o,
  output logic [AXI_PROT_W-1:0]  m_axi_awprot_o,
  output logic [AXI_QOS_W-1:0]   m_axi_awqos_o,
  output logic                   m_axi_awvalid_o,
  input  logic                   m_axi_awready_i,
  // AXI4 write data channel
  output logic [DATA_W-1:0]      m_axi_wdata_o,
  output logic [DATA_W/8-1:0]    m_axi_wstrb_o,
  output logic                   m_axi_wlast_o,
  output logic                   m_axi_wvalid_o,
  input  logic                   m_axi_wready_i,
  // AXI4 write response channel
  input  logic [AXI_RESP_W-1:0]  m_axi_bresp_i,
  input  logic                   m_axi_bvalid_i,
  output logic                   m_axi_bready_o,
  // native read master
  output logic                   m_valid_o,
  output logic [ADDR_W-1:0]      m_addr_o,
  input  logic [DATA_W-1:0]      m_rdata_i,
  input  logic [DATA_W/8-1:0]    m_rstrb_i,
  input  logic                   m_ready_i
);

  // Handshakes: a transfer happens on a channel in the cycle where both valid
  // and ready are 1; once valid is raised it and its payload hold until then.

  localparam int STRB_W  = DATA_W / 8;
  localparam int BYTE_SH = $clog2(STRB_W);
  localparam int BL_W    = $clog2(MAX_BURST) + 1;
  localparam logic [ADDR_W-1:0] BYTE_MASK = ADDR_W'(STRB_W - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [BL_W-1:0]   fetch_q, fetch_d;
  logic [BL_W-1:0]   sent_q, sent_d;
  logic              buf_valid_q, buf_valid_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [STRB_W-1:0] buf_strb_q, buf_strb_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic [BL_W-1:0]   blen;
  logic [LEN_W-1:0]  remain_next;
  logic              fetch, drain, last_beat;

  // addr_q/remain_q only move on a B handshake, so blen is stable for a burst.
  iob2axi_burst_len #(
    .DATA_W   (DATA_W),
    .LEN_W    (LEN_W),
    .MAX_BURST(MAX_BURST),
    .BL_W     (BL_W)
  ) u_burst_len (
    .addr_i     (addr_q[AXI_4K_W-1:0]),
    .remaining_i(remain_q),
    .len_o      (blen)
  );

  assign last_beat   = (sent_q == blen - 1'b1);
  assign drain       = buf_valid_q & m_axi_wready_i;
  assign m_valid_o   = (state_q == ST_DATA) && (fetch_q < blen) && (!buf_valid_q || drain);
  assign fetch       = m_valid_o & m_ready_i;
  assign m_addr_o    = addr_q + (ADDR_W'(fetch_q) << BYTE_SH);
  assign remain_next = remain_q - LEN_W'(blen);

  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = done_q;
  assign error_o = err_q;
  assign state_o = state_q;

  assign m_axi_awid_o    = '0;
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awlen_o   = AXI_LEN_W'(blen - 1'b1);
  assign m_axi_awsize_o  = AXI_SIZE_W'(BYTE_SH);
  assign m_axi_awburst_o = AXI_BURST_INCR;
  assign m_axi_awlock_o  = '0;
  assign m_axi_awcache_o = AXI_CACHE_W'(2);
  assign m_axi_awprot_o  = AXI_PROT_W'(2);
  assign m_axi_awqos_o   = '0;
  assign m_axi_awvalid_o = (state_q == ST_AW);

  assign m_axi_wdata_o  = buf_data_q;
  assign m_axi_wstrb_o  = buf_strb_q;
  assign m_axi_wvalid_o = buf_valid_q;
  assign m_axi_wlast_o  = buf_valid_q & last_beat;
  assign m_axi_bready_o = (state_q == ST_RESP);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    fetch_d     = fetch_q;
    sent_d      = sent_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    buf_strb_d  = buf_strb_q;
    err_d       = err_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_i) begin
          err_d    = 1'b0;
          addr_d   = addr_i & ~BYTE_MASK;
          remain_d = nwords_i;
          fetch_d  = '0;
          sent_d   = '0;
          if (nwords_i == '0) done_d = 1'b1;
          else                state_d = ST_AW;
        end
      end
      ST_AW: begin
        if (m_axi_awready_i) state_d = ST_DATA;
      end
      ST_DATA: begin
        // A fetch only happens when the buffer is empty or draining, so a
        // load always wins over the drain-clear.
        if (fetch) begin
          buf_valid_d = 1'b1;
          buf_data_d  = m_rdata_i;
          buf_strb_d  = m_rstrb_i;
          fetch_d     = fetch_q + 1'b1;
        end else if (drain) begin
          buf_valid_d = 1'b0;
        end
        if (drain) begin
          sent_d = sent_q + 1'b1;
          if (last_beat) begin
            state_d = ST_RESP;
            fetch_d = '0;
            sent_d  = '0;
          end
        end
      end
      ST_RESP: begin
        if (m_axi_bvalid_i) begin
          err_d    = err_q | (|m_axi_bresp_i);
          addr_d   = addr_q + (ADDR_W'(blen) << BYTE_SH);
          remain_d = remain_next;
          if (remain_next == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_AW;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      fetch_q     <= '0;
      sent_q      <= '0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      buf_strb_q  <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      fetch_q     <= fetch_d;
      sent_q      <= sent_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      buf_strb_q  <= buf_strb_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_iob2axi_wr_split.sv
// Directed vector bench for iob2axi_wr_split (DATA_W=32, MAX_BURST=16) with a
// native memory model, random AXI back-pressure and an AXI beat checker.
module tb_iob2axi_wr_split;
  import iob2axi_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int LEN_W     = 16;
  localparam int MAX_BURST = 16;
  localparam int BUDGET    = 2000;

  // ---------------- clock / reset ----------------
  logic clk_i    = 1'b0;
  logic arst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                   run_i = 1'b0;
  logic [ADDR_W-1:0]      addr_i = '0;
  logic [LEN_W-1:0]       nwords_i = '0;
  logic                   busy_o, done_o, error_o;
  logic [1:0]             state_o;
  logic [AXI_ID_W-1:0]    awid;
  logic [ADDR_W-1:0]      awaddr;
  logic [AXI_LEN_W-1:0]   awlen;
  logic [AXI_SIZE_W-1:0]  awsize;
  logic [AXI_BURST_W-1:0] awburst;
  logic [AXI_LOCK_W-1:0]  awlock;
  logic [AXI_CACHE_W-1:0] awcache;
  logic [AXI_PROT_W-1:0]  awprot;
  logic [AXI_QOS_W-1:0]   awqos;
  logic                   awvalid;
  logic                   awready = 1'b0;
  logic [DATA_W-1:0]      wdata;
  logic [DATA_W/8-1:0]    wstrb;
  logic                   wlast, wvalid;
  logic                   wready = 1'b0;
  logic [1:0]             bresp = 2'b00;
  logic                   bvalid = 1'b0;
  logic                   bready;
  logic                   m_valid_o;
  logic [ADDR_W-1:0]      m_addr_o;
  logic [DATA_W-1:0]      m_rdata_i;
  logic [DATA_W/8-1:0]    m_rstrb_i;
  logic                   m_ready_i = 1'b0;

  iob2axi_wr_split #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .run_i(run_i), .addr_i(addr_i), .nwords_i(nwords_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .state_o(state_o),
    .m_axi_awid_o(awid), .m_axi_awaddr_o(awaddr), .m_axi_awlen_o(awlen),
    .m_axi_awsize_o(awsize), .m_axi_awburst_o(awburst), .m_axi_awlock_o(awlock),
    .m_axi_awcache_o(awcache), .m_axi_awprot_o(awprot), .m_axi_awqos_o(awqos),
    .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
    .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast),
    .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
    .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready),
    .m_valid_o(m_valid_o), .m_addr_o(m_addr_o), .m_rdata_i(m_rdata_i),
    .m_rstrb_i(m_rstrb_i), .m_ready_i(m_ready_i)
  );

  // Native memory model: word content and strobe derived from its address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction
  assign m_rdata_i = word_of(m_addr_o);
  assign m_rstrb_i = m_addr_o[5:2];

  // ---------------- vectors ----------------
  typedef struct packed {
    logic [31:0]      addr;
    logic [15:0]      n;
    logic             toggle;    // wready pattern 1010
    logic [3:0]       err_burst; // burst index answered with SLVERR, 15 = none
    logic [3:0]       nb;
    logic             exp_err;
    logic [3:0][31:0] aw_addr;
    logic [3:0][7:0]  aw_len;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic [15:0] n,
                              input logic tg, input logic [3:0] eb,
                              input logic [3:0] nb, input logic ee,
                              input logic [31:0] a0, input logic [7:0] l0,
                              input logic [31:0] a1, input logic [7:0] l1,
                              input logic [31:0] a2, input logic [7:0] l2);
    vec_t v;
    v = '0;
    v.addr = a; v.n = n; v.toggle = tg; v.err_burst = eb;
    v.nb = nb; v.exp_err = ee;
    v.aw_addr[0] = a0; v.aw_len[0] = l0;
    v.aw_addr[1] = a1; v.aw_len[1] = l1;
    v.aw_addr[2] = a2; v.aw_len[2] = l2;
    return v;
  endfunction

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passes = 0;
  vec_t cur;
  logic [31:0] base, wa;
  int aw_idx, word_idx, beat, b_idx, done_cnt, done_cyc, last_b_cyc, cyc, mval_cnt;
  bit b_pend, aw_hold, w_hold, busy1;
  logic [40:0] aw_saved;
  logic [37:0] w_saved;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver ----------------
  task automatic start_xfer(input vec_t v);
    cur = v;
    aw_idx = 0; word_idx = 0; beat = 0; b_idx = 0; done_cnt = 0;
    done_cyc = -1; last_b_cyc = -1; mval_cnt = 0;
    b_pend = 0; aw_hold = 0; w_hold = 0; busy1 = 0;
    base = {v.addr[31:2], 2'b00};
    bvalid = 1'b0;
    run_i = 1'b1; addr_i = v.addr; nwords_i = v.n;
    @(negedge clk_i);
    run_i = 1'b0;
    cyc = 1;
  endtask

  // Called at a falling edge: drive inputs, then sample what the next rising
  // edge will see.
  task automatic drive_cycle();
    int li;
    awready   = 1'($urandom_range(0, 1));
    wready    = cur.toggle ? 1'(cyc % 2) : ($urandom_range(0, 3) != 0);
    m_ready_i = ($urandom_range(0, 3) != 0);
    bvalid    = b_pend;
    bresp     = (b_pend && (b_idx == int'(cur.err_burst))) ? 2'b10 : 2'b00;
    run_i     = busy_o ? 1'($urandom_range(0, 1)) : 1'b0;
    addr_i    = $urandom;
    nwords_i  = 16'($urandom_range(0, 60));
    #1;
    if (cyc == 1) busy1 = busy_o;
    if (aw_hold) check("aw_stable", {23'b0, awvalid, awaddr, awlen}, {23'b0, 1'b1, aw_saved[39:0]});
    if (w_hold) check("w_stable", {26'b0, wvalid, wdata, wstrb, wlast}, {26'b0, w_saved});
    aw_hold  = awvalid && !awready;
    aw_saved = {1'b1, awaddr, awlen};
    w_hold   = wvalid && !wready;
    w_saved  = {1'b1, wdata, wstrb, wlast};
    if (m_valid_o) mval_cnt++;
    if (awvalid && awready) begin
      li = (aw_idx < 4) ? aw_idx : 3;
      check("awaddr", awaddr, cur.aw_addr[li]);
      check("awlen", awlen, cur.aw_len[li]);
      if (aw_idx == 0)
        check("aw_attr", {awsize, awburst, awcache, awprot, awid, awlock, awqos},
                         {3'd2, 2'b01, 4'd2, 3'd2, 1'b0, 1'b0, 4'd0});
      aw_idx++;
    end
    if (wvalid && wready) begin
      li = (aw_idx > 0) ? ((aw_idx < 5) ? aw_idx - 1 : 3) : 0;
      wa = base + 32'(word_idx) * 32'd4;
      check("wdata", wdata, word_of(wa));
      check("wstrb", wstrb, wa[5:2]);
      check("wlast", wlast, beat == int'(cur.aw_len[li]));
      word_idx++;
      beat++;
      if (wlast) begin
        beat = 0;
        b_pend = 1;
      end
    end
    if (bvalid && bready) begin
      b_pend = 0;
      b_idx++;
      last_b_cyc = cyc;
    end
    if (done_o) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
      check("error_at_done", error_o, cur.exp_err);
    end
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic run_xfer(input vec_t v);
    start_xfer(v);
    while (done_cnt == 0 && cyc < BUDGET) drive_cycle();
    check("done_seen", done_cnt, 1);
    repeat (3) drive_cycle();
    check("done_once", done_cnt, 1);
    check("aw_count", aw_idx, v.nb);
    check("b_count", b_idx, v.nb);
    check("word_count", word_idx, v.n);
    check("busy_after_run", busy1, v.n != 0);
    check("idle_after_done", {busy_o, state_o}, {1'b0, ST_IDLE});
    check("error_hold", error_o, v.exp_err);
    if (v.n == 0) begin
      check("n0_done_cycle", done_cyc, 1);
      check("n0_no_native", mval_cnt, 0);
    end else begin
      check("done_after_last_b", done_cyc, last_b_cyc + 1);
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs[8];
  vec_t v_err;
  int dseen;

  initial begin
    vecs[0] = mk(32'h000, 16, 0, 15, 1, 0, 32'h000, 15, 0, 0, 0, 0);
    vecs[1] = mk(32'h000, 40, 0, 15, 3, 0, 32'h000, 15, 32'h040, 15, 32'h080, 7);
    vecs[2] = mk(32'hFF8, 4, 0, 15, 2, 0, 32'hFF8, 1, 32'h1000, 1, 0, 0);
    vecs[3] = mk(32'h200, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4] = mk(32'h000, 40, 1, 1, 3, 1, 32'h000, 15, 32'h040, 15, 32'h080, 7);
    vecs[5] = mk(32'h103, 3, 0, 15, 1, 0, 32'h100, 2, 0, 0, 0, 0);
    vecs[6] = mk(32'hFC0, 20, 0, 15, 2, 0, 32'hFC0, 15, 32'h1000, 3, 0, 0);
    vecs[7] = mk(32'h2000, 1, 0, 0, 1, 1, 32'h2000, 0, 0, 0, 0, 0);
    cur = vecs[0];

    repeat (2) @(negedge clk_i);
    check("reset_outputs", {busy_o, done_o, error_o, awvalid, wvalid, bready, m_valid_o, state_o},
                           {7'b0, ST_IDLE});
    arst_n_i = 1'b1;

    for (int i = 0; i < 8; i++) run_xfer(vecs[i]);

    // Reset in the middle of burst 2 after burst 1 returned SLVERR.
    v_err = mk(32'h000, 40, 1, 0, 3, 1, 32'h000, 15, 32'h040, 15, 32'h080, 7);
    start_xfer(v_err);
    while ((aw_idx < 2 || word_idx < 20) && cyc < BUDGET) drive_cycle();
    check("mid_reset_reached", (aw_idx >= 2 && word_idx >= 20), 1'b1);
    check("error_before_reset", error_o, 1'b1);
    #2 arst_n_i = 1'b0;
    #1;
    check("mid_reset_outputs", {busy_o, done_o, error_o, awvalid, wvalid, bready, m_valid_o, state_o},
                               {7'b0, ST_IDLE});
    bvalid = 1'b0;
    dseen = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (done_o) dseen++;
    end
    check("no_done_in_reset", dseen, 0);
    arst_n_i = 1'b1;
    run_xfer(mk(32'h100, 4, 0, 15, 1, 0, 32'h100, 3, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
